count_seg7_scan: RTL and testbench
==================================

// Module: count_seg7_scan
// PURPOSE
//  Displays the 4-bit LED counter value (0..15) as two decimal digits on a
//  4-digit multiplexed common-anode 7-segment display.
//  - Sits downstream of the divided-clock counter; runs entirely on the
//    fast board clock.
//  - The count input is resynchronised and stability-filtered, then latched
//    once per scan frame so a digit pair never shows mixed values.
//  - A dark interval between digit slots prevents ghosting.
// PARAMETERS
//  REFRESH_DIV   100000  clk cycles each digit slot is lit (>=2); 1 kHz/slot at 100 MHz
//  BLANK_CYCLES  1000    clk cycles all anodes off between slots (>=1)
//  LZ_BLANK      1       1: tens digit dark when tens==0; 0: show leading '0'
// PORTS
//  clk       in   1  board clock
//  reset     in   1  synchronous, active-high
//  count_in  in   4  counter value; may change on any clk edge
//  an        out  4  digit anodes, active-low; an[0]=ones, an[1]=tens
//  seg       out  7  segments, active-low, {g,f,e,d,c,b,a}
//  dp        out  1  decimal point, active-low; constant 1 (off) in this block
// BEHAVIOUR
//  Clocking and reset
//  - Single clock clk; reset is synchronous and active-high, sampled on posedge clk.
//  - Reset values: an=4'b1111, seg=7'h7F, dp=1, state=S_BLANK, slot=3,
//    prescaler=0, blank counter=0, sync/stable/display registers=0.
//  - Reset asserted in any state (mid-slot or mid-blank) forces reset values
//    on the next edge.
//  Input path
//  - count_in passes through two flops (s1, s2) and a history flop s3.
//  - stable <= s2 only when s2==s3; a value present for 1 clk is never captured.
//  Scan FSM (2 states + 2-bit slot index)
//  - S_BLANK: an=1111, seg=7F. Blank counter runs 0..BLANK_CYCLES-1.
//    On the terminal count: slot <= slot+1 (3 wraps to 0), go to S_ON,
//    prescaler <= 0.
//  - Frame boundary: entering S_ON with slot 0 loads disp <= stable.
//    disp is held for the whole frame.
//  - S_ON: prescaler runs 0..REFRESH_DIV-1. On the terminal count: go to
//    S_BLANK, blank counter <= 0.
//  - Out of reset the first lit slot is slot 0, after BLANK_CYCLES cycles
//    of blank.
//  Outputs
//  - an, seg and dp are registered and change on the same edge as the state
//    or slot change.
//  - Slot 0: an=1110, seg=enc(ones).
//  - Slot 1: if LZ_BLANK && tens==0, an=1111 and seg=7F; else an=1101 and
//    seg=enc(tens).
//  - Slots 2 and 3: an=1111, seg=7F. These slots keep frame timing and duty
//    cycle uniform.
//  Arithmetic
//  - tens = (disp>=10); ones = disp - (tens ? 10 : 0). Computed on 4 bits,
//    no overflow possible.
//  - enc: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001,
//    5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
//  Timing
//  - Frame length = 4*(REFRESH_DIV+BLANK_CYCLES) clk.
//  - A count_in change is shown at most 4 clk + 1 frame later.
// TESTING  (REFRESH_DIV=4, BLANK_CYCLES=2, LZ_BLANK=1 unless stated)
//  - Reset: hold reset with count_in=7 -> an=1111, seg=7F, dp=1 throughout.
//    Release with count_in=0 -> 2 clk dark, then an=1110, seg=1000000 for
//    4 clk, then an=1111 for 2 clk.
//  - count_in=13 held -> per frame: ones slot seg=0110000 (3); tens slot
//    an=1101, seg=1111001 (1); slots 2,3 an=1111. Frame = 24 clk.
//  - count_in=5, LZ_BLANK=1 -> tens slot an=1111, seg=7F.
//    Same with LZ_BLANK=0 -> tens slot an=1101, seg=1000000.
//  - Change 9->10 during the tens slot -> remainder of frame still shows 9.
//    Next frame: ones=0, tens=1.
//  - One-cycle glitch 4->11->4 on count_in -> display never shows 11.
//    A 3-clk pulse of 11 is captured and shown at the next frame boundary.
//  - Reset pulsed mid S_ON and mid S_BLANK -> reset values on the next edge.
//    Sequence restarts exactly as in the first scenario.

Source files
------------

// File: rtl/count_seg7_scan.sv
// Two-digit decimal display of a 4-bit count on a 4-digit multiplexed common-anode 7-segment
// display. Input is resynchronised, stability-filtered and latched once per scan frame.
module count_seg7_scan #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter bit          LZ_BLANK     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count_in,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned PreW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BlkW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(REFRESH_DIV - 1);
  localparam logic [BlkW-1:0] BlkLast = BlkW'(BLANK_CYCLES - 1);

  typedef enum logic {StBlank, StOn} state_e;

  state_e          r_state, w_state_d;
  logic [1:0]      r_slot, w_slot_d;
  logic [PreW-1:0] r_pre, w_pre_d;
  logic [BlkW-1:0] r_blank, w_blank_d;
  logic [3:0]      r_s1, r_s2, r_s3, r_stable;
  logic [3:0]      r_disp, w_disp_d;
  logic [3:0]      r_an, w_an_d;
  logic [6:0]      r_seg, w_seg_d;
  logic            r_dp;
  logic            w_tens;
  logic [3:0]      w_ones;

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Scan sequencing; outputs are derived from the next state so they switch on the same edge.
  always_comb begin
    w_state_d = r_state;
    w_slot_d  = r_slot;
    w_pre_d   = r_pre;
    w_blank_d = r_blank;
    w_disp_d  = r_disp;
    unique case (r_state)
      StBlank: begin
        if (r_blank == BlkLast) begin
          w_state_d = StOn;
          w_slot_d  = r_slot + 2'd1;
          w_pre_d   = '0;
          if (w_slot_d == 2'd0) w_disp_d = r_stable;
        end else begin
          w_blank_d = r_blank + 1'b1;
        end
      end
      StOn: begin
        if (r_pre == PreLast) begin
          w_state_d = StBlank;
          w_blank_d = '0;
        end else begin
          w_pre_d = r_pre + 1'b1;
        end
      end
      default: w_state_d = StBlank;
    endcase
  end

  always_comb begin
    w_tens = (w_disp_d >= 4'd10);
    w_ones = w_disp_d - (w_tens ? 4'd10 : 4'd0);
    w_an_d  = 4'b1111;
    w_seg_d = 7'h7F;
    if (w_state_d == StOn) begin
      case (w_slot_d)
        2'd0: begin
          w_an_d  = 4'b1110;
          w_seg_d = enc(w_ones);
        end
        2'd1: begin
          if (!(LZ_BLANK && !w_tens)) begin
            w_an_d  = 4'b1101;
            w_seg_d = enc({3'b000, w_tens});
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StBlank;
      r_slot   <= 2'd3;
      r_pre    <= '0;
      r_blank  <= '0;
      r_s1     <= '0;
      r_s2     <= '0;
      r_s3     <= '0;
      r_stable <= '0;
      r_disp   <= '0;
      r_an     <= 4'b1111;
      r_seg    <= 7'h7F;
      r_dp     <= 1'b1;
    end else begin
      r_state  <= w_state_d;
      r_slot   <= w_slot_d;
      r_pre    <= w_pre_d;
      r_blank  <= w_blank_d;
      r_s1     <= count_in;
      r_s2     <= r_s1;
      r_s3     <= r_s2;
      // Only a value seen on two consecutive synchronised samples is accepted.
      if (r_s2 == r_s3) r_stable <= r_s2;
      r_disp   <= w_disp_d;
      r_an     <= w_an_d;
      r_seg    <= w_seg_d;
      r_dp     <= 1'b1;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_count_seg7_scan.sv
// Directed bench for count_seg7_scan: REFRESH_DIV=4, BLANK_CYCLES=2, with LZ_BLANK=1 and 0
// instances sharing stimulus; each scan slot is checked cycle by cycle.
module tb_count_seg7_scan;

  logic       clk;
  logic       reset;
  logic [3:0] count_in;
  logic [3:0] an, an2;
  logic [6:0] seg, seg2;
  logic       dp, dp2;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [11:0] Dark = {4'hF, 7'h7F, 1'b1};

  count_seg7_scan #(
    .REFRESH_DIV (4),
    .BLANK_CYCLES(2),
    .LZ_BLANK    (1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .count_in(count_in),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  count_seg7_scan #(
    .REFRESH_DIV (4),
    .BLANK_CYCLES(2),
    .LZ_BLANK    (1'b0)
  ) dut_lz0 (
    .clk     (clk),
    .reset   (reset),
    .count_in(count_in),
    .an      (an2),
    .seg     (seg2),
    .dp      (dp2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {an,seg,dp}=%03h expected %03h", tag, got, exp);
    end
  endtask

  task automatic check_dark(input string tag);
    check_eq({tag, " lz1"}, {an, seg, dp}, Dark);
    check_eq({tag, " lz0"}, {an2, seg2, dp2}, Dark);
  endtask

  // One slot: 2 dark cycles then 4 lit; optional count_in writes at given cycle indices.
  task automatic slot(input string tag, input logic [3:0] an1, input logic [6:0] sg1,
                      input logic [3:0] an2e, input logic [6:0] sg2, input int set_at,
                      input logic [3:0] sv, input int clr_at, input logic [3:0] cv);
    for (int i = 0; i < 6; i++) begin
      if (i == set_at) count_in = sv;
      if (i == clr_at) count_in = cv;
      if (i < 2) begin
        check_dark($sformatf("%s c%0d", tag, i));
      end else begin
        check_eq($sformatf("%s c%0d lz1", tag, i), {an, seg, dp}, {an1, sg1, 1'b1});
        check_eq($sformatf("%s c%0d lz0", tag, i), {an2, seg2, dp2}, {an2e, sg2, 1'b1});
      end
      tick();
    end
  endtask

  task automatic frame(input string tag, input logic [6:0] ones, input logic [3:0] t1an,
                       input logic [6:0] t1sg, input logic [3:0] t2an, input logic [6:0] t2sg,
                       input int ps, input int set_at, input logic [3:0] sv, input int clr_at,
                       input logic [3:0] cv);
    for (int s = 0; s < 4; s++) begin
      int sa, ca;
      string st;
      sa = (s == ps) ? set_at : -1;
      ca = (s == ps) ? clr_at : -1;
      st = $sformatf("%s s%0d", tag, s);
      case (s)
        0:       slot(st, 4'hE, ones, 4'hE, ones, sa, sv, ca, cv);
        1:       slot(st, t1an, t1sg, t2an, t2sg, sa, sv, ca, cv);
        default: slot(st, 4'hF, 7'h7F, 4'hF, 7'h7F, sa, sv, ca, cv);
      endcase
    end
  endtask

  initial begin
    reset    = 1'b1;
    count_in = 4'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_dark($sformatf("rst_hold%0d", i));
    end
    reset    = 1'b0;
    count_in = 4'd0;

    // value 0: lz1 blanks the tens digit, lz0 shows a leading '0'
    frame("f0_zero", 7'h40, 4'hF, 7'h7F, 4'hD, 7'h40, 1, 0, 4'd13, -1, 4'd0);
    frame("f1_13", 7'h30, 4'hD, 7'h79, 4'hD, 7'h79, -1, -1, 4'd0, -1, 4'd0);
    frame("f2_13", 7'h30, 4'hD, 7'h79, 4'hD, 7'h79, 1, 0, 4'd5, -1, 4'd0);
    frame("f3_5", 7'h12, 4'hF, 7'h7F, 4'hD, 7'h40, 1, 0, 4'd9, -1, 4'd0);
    // 10 arrives during the tens slot; the frame must keep showing 9
    frame("f4_9", 7'h10, 4'hF, 7'h7F, 4'hD, 7'h40, 1, 3, 4'd10, -1, 4'd0);
    frame("f5_10", 7'h40, 4'hD, 7'h79, 4'hD, 7'h79, 1, 0, 4'd4, -1, 4'd0);
    // one-cycle glitch to 11 late in the frame
    frame("f6_4", 7'h19, 4'hF, 7'h7F, 4'hD, 7'h40, 3, 1, 4'd11, 2, 4'd4);
    // three-cycle pulse of 11 timed to straddle the frame boundary
    frame("f7_4", 7'h19, 4'hF, 7'h7F, 4'hD, 7'h40, 3, 1, 4'd11, 4, 4'd4);
    frame("f8_11", 7'h79, 4'hD, 7'h79, 4'hD, 7'h79, -1, -1, 4'd0, -1, 4'd0);
    frame("f9_4", 7'h19, 4'hF, 7'h7F, 4'hD, 7'h40, -1, -1, 4'd0, -1, 4'd0);

    // reset in the middle of a lit slot
    check_dark("on_pre0");
    tick();
    check_dark("on_pre1");
    tick();
    check_eq("on_lit lz1", {an, seg, dp}, {4'hE, 7'h19, 1'b1});
    reset    = 1'b1;
    count_in = 4'd0;
    tick();
    check_dark("rst_mid_on");
    reset = 1'b0;
    frame("r1_zero", 7'h40, 4'hF, 7'h7F, 4'hD, 7'h40, -1, -1, 4'd0, -1, 4'd0);

    // reset in the middle of a blank interval
    check_dark("blk_pre0");
    tick();
    check_dark("blk_pre1");
    reset = 1'b1;
    tick();
    check_dark("rst_mid_blank");
    reset = 1'b0;
    frame("r2_zero", 7'h40, 4'hF, 7'h7F, 4'hD, 7'h40, -1, -1, 4'd0, -1, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
